// File: rtl/i2c_bit_timer_if.sv
// Bus between the I2C master FSM / SCL pad side and the SCL bit-timing engine.
// master = FSM and pad side, slave = the bit timer.
interface i2c_bit_timer_if #(
  parameter int unsigned CNT_W = 10
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] div_val;
  logic             scl_in;
  logic             scl_oe;
  logic [CNT_W-1:0] count;
  logic [1:0]       phase;
  logic             tick_drive;
  logic             tick_sample;
  logic             bit_done;
  logic             busy;
  logic             stretching;
  logic             stretch_timeout;

  modport master (
    output start, stop, div_val, scl_in,
    input  scl_oe, count, phase, tick_drive, tick_sample, bit_done,
           busy, stretching, stretch_timeout
  );

  modport slave (
    input  start, stop, div_val, scl_in,
    output scl_oe, count, phase, tick_drive, tick_sample, bit_done,
           busy, stretching, stretch_timeout
  );

endinterface

// File: rtl/i2c_bit_timer.sv
// Programmable SCL bit-timing engine: quarter-phase decode, drive/sample strobes,
// clock-stretch detection with timeout. Define I2C_BIT_TIMER_SYNC_EN to synchronise scl_in.
module i2c_bit_timer #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned MIN_DIV = 8,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input logic            clk,
  input logic            reset,
  i2c_bit_timer_if.slave sif
);

  localparam int unsigned EW = CNT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STRETCH = 2'd2,
    S_ABORT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  d_q, d_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        phase_q, phase_d;
  logic              scl_oe_q, scl_oe_d;
  logic              tick_drive_q, tick_drive_d;
  logic              tick_sample_q, tick_sample_d;
  logic              bit_done_q, bit_done_d;
  logic              busy_q, busy_d;
  logic              stretching_q, stretching_d;
  logic              stretch_timeout_q, stretch_timeout_d;

  logic              scl_s;
  logic [CNT_W-1:0]  d_load;
  logic [EW-1:0]     q_cur, q2_cur;
  logic [EW-1:0]     q_n, q2_n, q3_n, cnt_n;

`ifdef I2C_BIT_TIMER_SYNC_EN
  logic scl_meta_q, scl_meta_d;
  logic scl_sync_q, scl_sync_d;

  // Two-flop synchroniser; idles high like a released bus
  always_comb begin
    scl_meta_d = sif.scl_in;
    scl_sync_d = scl_meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
    end
  end

  assign scl_s = scl_sync_q;
`else
  assign scl_s = sif.scl_in;
`endif

  // Next-state, counter and divider latch
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    d_d     = d_q;
    to_d    = to_q;
    d_load  = (sif.div_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : sif.div_val;
    q_cur   = EW'(d_q >> 2);
    q2_cur  = q_cur << 1;

    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (sif.start) begin
          state_d = S_RUN;
          d_d     = d_load;
        end
      end
      S_RUN: begin
        if (count_q == d_q - CNT_W'(1)) begin
          count_d = '0;
          d_d     = d_load;
        end else if ((EW'(count_q) == q2_cur + EW'(SETTLE)) && !scl_s) begin
          state_d = S_STRETCH;
          to_d    = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_STRETCH: begin
        if (scl_s) begin
          state_d = S_RUN;
          count_d = count_q + CNT_W'(1);
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    // stop beats everything, including a simultaneous start
    if (sif.stop) begin
      state_d = S_IDLE;
      count_d = '0;
      d_d     = d_q;
    end
  end

  // Outputs are decoded from next-cycle values so the registered strobes line up with count
  always_comb begin
    q_n   = EW'(d_d >> 2);
    q2_n  = q_n << 1;
    q3_n  = q2_n + q_n;
    cnt_n = EW'(count_d);

    scl_oe_d          = (state_d == S_RUN) && (cnt_n < q2_n);
    tick_drive_d      = (state_d == S_RUN) && (cnt_n == q_n);
    tick_sample_d     = (state_d == S_RUN) && (cnt_n == q3_n);
    bit_done_d        = (state_d == S_RUN) && (count_d == d_d - CNT_W'(1));
    busy_d            = (state_d != S_IDLE);
    stretching_d      = (state_d == S_STRETCH);
    stretch_timeout_d = (state_d == S_ABORT);

    if (state_d == S_IDLE)   phase_d = 2'd0;
    else if (cnt_n < q_n)    phase_d = 2'd0;
    else if (cnt_n < q2_n)   phase_d = 2'd1;
    else if (cnt_n < q3_n)   phase_d = 2'd2;
    else                     phase_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      count_q           <= '0;
      d_q               <= CNT_W'(MIN_DIV);
      to_q              <= '0;
      phase_q           <= 2'd0;
      scl_oe_q          <= 1'b0;
      tick_drive_q      <= 1'b0;
      tick_sample_q     <= 1'b0;
      bit_done_q        <= 1'b0;
      busy_q            <= 1'b0;
      stretching_q      <= 1'b0;
      stretch_timeout_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      d_q               <= d_d;
      to_q              <= to_d;
      phase_q           <= phase_d;
      scl_oe_q          <= scl_oe_d;
      tick_drive_q      <= tick_drive_d;
      tick_sample_q     <= tick_sample_d;
      bit_done_q        <= bit_done_d;
      busy_q            <= busy_d;
      stretching_q      <= stretching_d;
      stretch_timeout_q <= stretch_timeout_d;
    end
  end

  assign sif.scl_oe          = scl_oe_q;
  assign sif.count           = count_q;
  assign sif.phase           = phase_q;
  assign sif.tick_drive      = tick_drive_q;
  assign sif.tick_sample     = tick_sample_q;
  assign sif.bit_done        = bit_done_q;
  assign sif.busy            = busy_q;
  assign sif.stretching      = stretching_q;
  assign sif.stretch_timeout = stretch_timeout_q;

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Self-checking bench for i2c_bit_timer: cycle model compared every cycle plus
// directed scenarios with hand-computed expectations.
module tb_i2c_bit_timer;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned MIN_DIV = 8;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TO_W    = 16;
  localparam int unsigned TIMEOUT = 100;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STR  = 2;
  localparam int M_ABT  = 3;

  typedef struct {
    int st;
    int cnt;
    int d;
    int waited;
  } mdl_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  mdl_t m;
  logic [18:0] ev, av;

  i2c_bit_timer_if #(.CNT_W(CNT_W)) bus ();

  i2c_bit_timer #(
    .CNT_W  (CNT_W),
    .MIN_DIV(MIN_DIV),
    .SETTLE (SETTLE),
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sif  (bus)
  );

  always #5 clk = ~clk;

  // Bit-level behaviour: where in the bit we are, which period applies, how long SCL has been held
  function automatic mdl_t step(input mdl_t c, input logic rst, input logic sta,
                                input logic sto, input int dv, input logic scl);
    mdl_t n;
    int   q;
    n = c;
    q = c.d / 4;
    if (rst) begin
      n.st = M_IDLE; n.cnt = 0; n.d = int'(MIN_DIV); n.waited = 0;
    end else if (sto) begin
      n.st = M_IDLE; n.cnt = 0;
    end else if (c.st == M_IDLE) begin
      if (sta) begin
        n.st = M_RUN; n.cnt = 0;
        n.d  = (dv < int'(MIN_DIV)) ? int'(MIN_DIV) : dv;
      end
    end else if (c.st == M_RUN) begin
      if (c.cnt == c.d - 1) begin
        n.cnt = 0;
        n.d   = (dv < int'(MIN_DIV)) ? int'(MIN_DIV) : dv;
      end else if (c.cnt == 2 * q + int'(SETTLE) && !scl) begin
        n.st = M_STR; n.waited = 1;
      end else begin
        n.cnt = c.cnt + 1;
      end
    end else if (c.st == M_STR) begin
      if (scl) begin
        n.st = M_RUN; n.cnt = c.cnt + 1;
      end else if (c.waited >= int'(TIMEOUT)) begin
        n.st = M_ABT;
      end else begin
        n.waited = c.waited + 1;
      end
    end else begin
      n.st = M_IDLE; n.cnt = 0;
    end
    return n;
  endfunction

  function automatic logic [18:0] expect_vec(input mdl_t c);
    int   q, ph;
    logic run;
    q   = (c.d < 4) ? 1 : c.d / 4;
    ph  = c.cnt / q;
    if (ph > 3) ph = 3;
    run = (c.st == M_RUN);
    return {run && (c.cnt < 2 * q), CNT_W'(c.cnt), 2'(ph),
            run && (c.cnt == q), run && (c.cnt == 3 * q), run && (c.cnt == c.d - 1),
            c.st != M_IDLE, c.st == M_STR, c.st == M_ABT};
  endfunction

  always @(posedge clk)
    m <= step(m, reset, bus.start, bus.stop, int'(bus.div_val), bus.scl_in);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n, output logic [31:0] oe, output logic [31:0] drv,
                         output logic [31:0] smp, output logic [31:0] dn);
    oe = '0; drv = '0; smp = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      oe[i]  = bus.scl_oe;
      drv[i] = bus.tick_drive;
      smp[i] = bus.tick_sample;
      dn[i]  = bus.bit_done;
      tick();
    end
  endtask

  initial begin
    logic [31:0] oe, drv, smp, dn;
    int n;
    bit seen;
    bit frozen;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.div_val = 10'd16;
    bus.scl_in  = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          ev = expect_vec(m);
          av = {bus.scl_oe, bus.count, bus.phase, bus.tick_drive, bus.tick_sample,
                bus.bit_done, bus.busy, bus.stretching, bus.stretch_timeout};
          checks++;
          if (av !== ev) begin
            errors++;
            $display("FAIL model_cycle at %0t dut=%h expected=%h", $time, av, ev);
          end
        end
      end
    join_none

    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_scl_oe", int'(bus.scl_oe), 0);
    chk("rst_phase", int'(bus.phase), 0);
    reset = 1'b0;
    tick();

    // div 16, free-running
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("t1_first_count", int'(bus.count), 0);
    collect(16, oe, drv, smp, dn);
    chk("t1_oe", int'(oe), 'h00FF);
    chk("t1_drive", int'(drv), 'h0010);
    chk("t1_sample", int'(smp), 'h1000);
    chk("t1_done", int'(dn), 'h8000);
    chk("t1_wrap", int'(bus.count), 0);
    collect(16, oe, drv, smp, dn);
    chk("t1_rep_done", int'(dn), 'h8000);

    // div 4 clamps to 8
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    bus.div_val = 10'd4;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    collect(8, oe, drv, smp, dn);
    chk("t2_oe", int'(oe), 'h0F);
    chk("t2_drive", int'(drv), 'h04);
    chk("t2_sample", int'(smp), 'h40);
    chk("t2_done", int'(dn), 'h80);
    chk("t2_wrap", int'(bus.count), 0);

    // 20-cycle stretch at count 10
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    bus.div_val = 10'd16;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (10) tick();
    chk("t3_at10", int'(bus.count), 10);
    bus.scl_in = 1'b0;
    n = 0; frozen = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n += int'(bus.stretching);
      if (bus.count != 10'd10) frozen = 1'b0;
    end
    chk("t3_stretch_cycles", n, 20);
    chk("t3_frozen", int'(frozen), 1);
    bus.scl_in = 1'b1;
    tick();
    chk("t3_resume_count", int'(bus.count), 11);
    chk("t3_resume_stretching", int'(bus.stretching), 0);
    repeat (4) tick();
    chk("t3_done_count", int'(bus.count), 15);
    chk("t3_done", int'(bus.bit_done), 1);

    // stretch timeout after TIMEOUT cycles
    tick();
    chk("t4_new_bit", int'(bus.count), 0);
    repeat (10) tick();
    bus.scl_in = 1'b0;
    n = 0; seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      if (bus.stretch_timeout) seen = 1'b1;
      else n += int'(bus.stretching);
    end
    chk("t4_timeout_seen", int'(seen), 1);
    chk("t4_stretch_cycles", n, 100);
    tick();
    chk("t4_busy_after", int'(bus.busy), 0);
    chk("t4_count_after", int'(bus.count), 0);
    chk("t4_pulse_width", int'(bus.stretch_timeout), 0);
    bus.scl_in = 1'b1;

    // div change mid-bit and start while busy
    bus.div_val = 10'd16;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (5) tick();
    chk("t5_at5", int'(bus.count), 5);
    bus.start = 1'b1; bus.div_val = 10'd32;
    tick();
    bus.start = 1'b0;
    chk("t5_start_ignored", int'(bus.count), 6);
    repeat (9) tick();
    chk("t5_old_end", int'(bus.count), 15);
    chk("t5_old_done", int'(bus.bit_done), 1);
    tick();
    chk("t5_new_bit", int'(bus.count), 0);
    repeat (31) tick();
    chk("t5_new_end", int'(bus.count), 31);
    chk("t5_new_done", int'(bus.bit_done), 1);
    tick();
    chk("t5_wrap", int'(bus.count), 0);

    // stop in RUN, then start+stop together
    repeat (3) tick();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("t6_stop_busy", int'(bus.busy), 0);
    chk("t6_stop_count", int'(bus.count), 0);
    bus.start = 1'b1; bus.stop = 1'b1; tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t6_both_busy", int'(bus.busy), 0);
    tick();
    chk("t6_both_busy2", int'(bus.busy), 0);

    // reset during stretch
    bus.div_val = 10'd16;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (10) tick();
    bus.scl_in = 1'b0;
    repeat (3) tick();
    chk("t7_stretching", int'(bus.stretching), 1);
    reset = 1'b1; tick();
    chk("t7_count", int'(bus.count), 0);
    chk("t7_busy", int'(bus.busy), 0);
    chk("t7_stretching_clr", int'(bus.stretching), 0);
    chk("t7_scl_oe", int'(bus.scl_oe), 0);
    chk("t7_phase", int'(bus.phase), 0);
    reset = 1'b0; bus.scl_in = 1'b1;
    repeat (3) tick();
    chk("t7_stays_idle", int'(bus.busy), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
